// File: rtl/audio_sample_buffer_pkg.sv
// Shared types and constants for the audio sample buffer.
// FSM encoding plus sample/frame widths.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAYING  = 2'd1,
    ST_DRAINING = 2'd2
  } state_t;

  localparam int SAMPLE_W = 16;
  localparam int FRAME_W  = 32;

endpackage

// File: rtl/audio_sample_buffer_if.sv
// Op-strobe inputs and DAC-side outputs of the audio sample buffer.
// master = decoder/DAC side, slave = the buffer.
interface audio_sample_buffer_if #(
  parameter int AW = 4
);
  import audio_pkg::*;

  logic                is_audio_sample;
  logic                audio_starts;
  logic                end_audio_sample;
  logic                audio_22khz;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_tick;
  logic [SAMPLE_W-1:0] sample_left;
  logic [SAMPLE_W-1:0] sample_right;
  logic                sample_valid;
  logic                playing;
  logic                audio_req;
  logic                underrun;
  logic                overflow;
  logic [AW:0]         level;

  modport master (
    output is_audio_sample,
    output audio_starts,
    output end_audio_sample,
    output audio_22khz,
    output sample_data,
    output sample_tick,
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    input  playing,
    input  audio_req,
    input  underrun,
    input  overflow,
    input  level
  );

  modport slave (
    input  is_audio_sample,
    input  audio_starts,
    input  end_audio_sample,
    input  audio_22khz,
    input  sample_data,
    input  sample_tick,
    output sample_left,
    output sample_right,
    output sample_valid,
    output playing,
    output audio_req,
    output underrun,
    output overflow,
    output level
  );

endinterface

// File: rtl/audio_sample_buffer_fifo.sv
// Show-ahead stereo frame FIFO with extra-bit pointers.
// A write into a full FIFO is accepted when a read happens the same cycle.
module sample_frame_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [FRAME_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [FRAME_W-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        level
);

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_rd;
  logic               do_wr;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/audio_sample_buffer.sv
// Pairs sample words into stereo frames, buffers them and plays them
// out at the frame tick, with 22 kHz frame repeat and flow flags.
module audio_sample_buffer
  import audio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  audio_sample_buffer_if.slave   bus
);

  localparam logic [AW:0] HALF = (AW+1)'(DEPTH/2);

  state_t              state;
  state_t              state_nx;
  logic                pair_pending;
  logic                rate_22k;
  logic                repeat_phase;
  logic [SAMPLE_W-1:0] left_hold;

  logic                pop;
  logic                replay;
  logic                silence;
  logic                drain_done;
  logic                frame_done;
  logic                rate_latch;
  logic                go_play;

  logic [FRAME_W-1:0]  rd_data;
  logic                full;
  logic                empty;
  logic [AW:0]         level;

  assign frame_done = bus.is_audio_sample && pair_pending;

  sample_frame_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (frame_done),
    .wr_data ({left_hold, bus.sample_data}),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    replay     = 1'b0;
    silence    = 1'b0;
    drain_done = 1'b0;
    if (bus.sample_tick && state != ST_IDLE) begin
      if (rate_22k && repeat_phase)   replay     = 1'b1;
      else if (!empty)                pop        = 1'b1;
      else if (state == ST_PLAYING)   silence    = 1'b1;
      else                            drain_done = 1'b1;
    end
    unique case (state)
      ST_IDLE: begin
        if (bus.audio_starts && !bus.end_audio_sample)
          state_nx = ST_PLAYING;
      end
      ST_PLAYING: begin
        if (bus.end_audio_sample) state_nx = ST_DRAINING;
      end
      ST_DRAINING: begin
        if (drain_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // end_audio_sample beats a simultaneous start; DRAINING ignores starts
  assign rate_latch = bus.audio_starts && !bus.end_audio_sample &&
                      state != ST_DRAINING;
  assign go_play    = rate_latch && state == ST_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_pending <= 1'b0;
      left_hold    <= '0;
      rate_22k     <= 1'b0;
      repeat_phase <= 1'b0;
    end else begin
      if (drain_done) begin
        pair_pending <= 1'b0;
      end else if (bus.is_audio_sample) begin
        pair_pending <= !pair_pending;
        if (!pair_pending) left_hold <= bus.sample_data;
      end
      if (rate_latch) rate_22k <= bus.audio_22khz;
      if (go_play)     repeat_phase <= 1'b0;
      else if (pop)    repeat_phase <= rate_22k;
      else if (replay) repeat_phase <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sample_left  <= '0;
      bus.sample_right <= '0;
      bus.sample_valid <= 1'b0;
      bus.underrun     <= 1'b0;
      bus.overflow     <= 1'b0;
    end else begin
      bus.sample_valid <= pop || replay || silence;
      bus.underrun     <= silence;
      bus.overflow     <= frame_done && full && !pop;
      if (pop) begin
        bus.sample_left  <= rd_data[FRAME_W-1:SAMPLE_W];
        bus.sample_right <= rd_data[SAMPLE_W-1:0];
      end else if (silence) begin
        bus.sample_left  <= '0;
        bus.sample_right <= '0;
      end
    end
  end

  assign bus.playing   = (state != ST_IDLE);
  assign bus.audio_req = (state == ST_PLAYING) && (level <= HALF);
  assign bus.level     = level;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Directed bench for audio_sample_buffer with hand-computed expectations.
module tb_audio_sample_buffer;

  logic clk;
  logic reset;
  int   total;
  int   passes;

  audio_sample_buffer_if #(.AW(4)) bus ();

  audio_sample_buffer #(.DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [15:0] w);
    bus.is_audio_sample = 1'b1;
    bus.sample_data     = w;
    step();
    bus.is_audio_sample = 1'b0;
    bus.sample_data     = 16'hxxxx;
  endtask

  task automatic tick();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
  endtask

  task automatic start(input logic r);
    bus.audio_starts = 1'b1;
    bus.audio_22khz  = r;
    step();
    bus.audio_starts = 1'b0;
    bus.audio_22khz  = 1'b0;
  endtask

  task automatic frame_out(input string tag, input logic [15:0] l,
                           input logic [15:0] r, input int lvl);
    chk({tag, "_valid"}, 32'(bus.sample_valid), 32'd1);
    chk({tag, "_L"}, 32'(bus.sample_left), 32'(l));
    chk({tag, "_R"}, 32'(bus.sample_right), 32'(r));
    chk({tag, "_lvl"}, 32'(bus.level), 32'(lvl));
  endtask

  initial begin
    total  = 0;
    passes = 0;
    reset  = 1'b1;
    bus.is_audio_sample  = 1'b0;
    bus.audio_starts     = 1'b0;
    bus.end_audio_sample = 1'b0;
    bus.audio_22khz      = 1'b0;
    bus.sample_data      = 16'h0;
    bus.sample_tick      = 1'b0;
    step();
    step();
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_playing", 32'(bus.playing), 32'd0);
    chk("rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("rst_req", 32'(bus.audio_req), 32'd0);
    chk("rst_L", 32'(bus.sample_left), 32'd0);
    reset = 1'b0;
    step();

    // basic 44 kHz playback
    start(1'b0);
    chk("b_playing", 32'(bus.playing), 32'd1);
    chk("b_req", 32'(bus.audio_req), 32'd1);
    word(16'h1111);
    word(16'h2222);
    word(16'h3333);
    word(16'h4444);
    chk("b_level", 32'(bus.level), 32'd2);
    tick();
    frame_out("b_t1", 16'h1111, 16'h2222, 1);
    step();
    chk("b_valid_low", 32'(bus.sample_valid), 32'd0);
    tick();
    frame_out("b_t2", 16'h3333, 16'h4444, 0);

    // underrun
    tick();
    chk("u_underrun", 32'(bus.underrun), 32'd1);
    frame_out("u", 16'h0, 16'h0, 0);
    chk("u_playing", 32'(bus.playing), 32'd1);
    chk("u_req", 32'(bus.audio_req), 32'd1);
    step();
    chk("u_pulse_end", 32'(bus.underrun), 32'd0);

    // 22 kHz repeat
    start(1'b1);
    word(16'hA0A0);
    word(16'hA1A1);
    word(16'hB0B0);
    word(16'hB1B1);
    chk("r_level", 32'(bus.level), 32'd2);
    tick();
    frame_out("r_t1", 16'hA0A0, 16'hA1A1, 1);
    tick();
    frame_out("r_t2", 16'hA0A0, 16'hA1A1, 1);
    tick();
    frame_out("r_t3", 16'hB0B0, 16'hB1B1, 0);
    tick();
    frame_out("r_t4", 16'hB0B0, 16'hB1B1, 0);
    chk("r_t4_no_underrun", 32'(bus.underrun), 32'd0);
    start(1'b0);

    // overflow, audio_req threshold
    for (int k = 0; k < 17; k++) begin
      word(16'(16'h0100 + 2 * k));
      word(16'(16'h0101 + 2 * k));
      if (k == 7) chk("o_req_at8", 32'(bus.audio_req), 32'd1);
      if (k == 8) chk("o_req_at9", 32'(bus.audio_req), 32'd0);
      if (k == 15) chk("o_no_ovf_16", 32'(bus.overflow), 32'd0);
    end
    chk("o_overflow", 32'(bus.overflow), 32'd1);
    chk("o_level_full", 32'(bus.level), 32'd16);
    step();
    chk("o_pulse_end", 32'(bus.overflow), 32'd0);

    // simultaneous write and pop while full
    word(16'h5555);
    bus.sample_tick = 1'b1;
    word(16'h6666);
    bus.sample_tick = 1'b0;
    frame_out("s", 16'h0100, 16'h0101, 16);
    chk("s_no_ovf", 32'(bus.overflow), 32'd0);

    // pop down to level 5, then async reset mid-cycle
    for (int k = 0; k < 11; k++) tick();
    frame_out("m", 16'h0116, 16'h0117, 5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar_level", 32'(bus.level), 32'd0);
    chk("ar_playing", 32'(bus.playing), 32'd0);
    chk("ar_valid", 32'(bus.sample_valid), 32'd0);
    chk("ar_L", 32'(bus.sample_left), 32'd0);
    chk("ar_R", 32'(bus.sample_right), 32'd0);
    step();
    reset = 1'b0;
    start(1'b0);
    word(16'hC0C0);
    word(16'hC1C1);
    tick();
    frame_out("ar_play", 16'hC0C0, 16'hC1C1, 0);

    // drain with odd word
    word(16'hD000);
    word(16'hD001);
    word(16'hD002);
    word(16'hD003);
    word(16'hDEEE);
    bus.end_audio_sample = 1'b1;
    step();
    bus.end_audio_sample = 1'b0;
    chk("d_playing", 32'(bus.playing), 32'd1);
    chk("d_req", 32'(bus.audio_req), 32'd0);
    tick();
    frame_out("d_t1", 16'hD000, 16'hD001, 1);
    tick();
    frame_out("d_t2", 16'hD002, 16'hD003, 0);
    tick();
    chk("d_t3_playing", 32'(bus.playing), 32'd0);
    chk("d_t3_valid", 32'(bus.sample_valid), 32'd0);
    chk("d_t3_underrun", 32'(bus.underrun), 32'd0);
    tick();
    chk("d_idle_hold_L", 32'(bus.sample_left), 32'hD002);
    chk("d_idle_valid", 32'(bus.sample_valid), 32'd0);
    word(16'hE000);
    word(16'hE001);
    chk("d_pair_level", 32'(bus.level), 32'd1);
    start(1'b0);
    tick();
    frame_out("d_pair", 16'hE000, 16'hE001, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
